// File: rtl/servant_wb_decoder.sv
// Wishbone address decoder and response mux between the SERV data bus and up to
// eight slaves, with registered responses, bus errors, ack timeout and fault capture.
module servant_wb_decoder #(
   parameter int NS = 4,
   parameter int SEL_W = 2,
   parameter logic [7:0] ACK_MASK = 8'b0000_1001,
   parameter int TIMEOUT = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [31:0]        i_wb_cpu_adr,
   input  logic [31:0]        i_wb_cpu_dat,
   input  logic [3:0]         i_wb_cpu_sel,
   input  logic               i_wb_cpu_we,
   input  logic               i_wb_cpu_cyc,
   output logic [31:0]        o_wb_cpu_rdt,
   output logic               o_wb_cpu_ack,
   output logic               o_wb_cpu_err,
   output logic [31:0]        o_wb_s_adr,
   output logic [31:0]        o_wb_s_dat,
   output logic [3:0]         o_wb_s_sel,
   output logic               o_wb_s_we,
   output logic [NS-1:0]      o_wb_s_cyc,
   input  logic [32*NS-1:0]   i_wb_s_rdt,
   input  logic [NS-1:0]      i_wb_s_ack,
   output logic               o_fault,
   output logic [31:0]        o_fault_adr
);

   localparam int NSLOT = 2 ** SEL_W;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [SEL_W:0] NS_L = (SEL_W + 1)'(NS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              ack_reg, ack_next;
   logic              err_reg, err_next;
   logic [31:0]       rdt_reg, rdt_next;
   logic              fault_reg, fault_next;
   logic [31:0]       fault_adr_reg, fault_adr_next;

   logic [SEL_W-1:0]  d;
   logic              mapped;
   logic              done;
   logic [NSLOT-1:0]  ack_pad;
   logic [NSLOT-1:0]  mask_pad;
   logic [31:0]       rdt_arr [NSLOT];

   assign d      = i_wb_cpu_adr[31 -: SEL_W];
   assign mapped = ({1'b0, d} < NS_L);

   // Pad per-slave inputs out to the full decode range so unmapped indices read as zero.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi < NS) begin : g_used
            assign ack_pad[gi]  = i_wb_s_ack[gi];
            assign mask_pad[gi] = ACK_MASK[gi];
            assign rdt_arr[gi]  = i_wb_s_rdt[32*gi +: 32];
         end else begin : g_unused
            assign ack_pad[gi]  = 1'b0;
            assign mask_pad[gi] = 1'b0;
            assign rdt_arr[gi]  = 32'h0;
         end
      end
      for (gi = 0; gi < NS; gi++) begin : g_cyc
         assign o_wb_s_cyc[gi] = i_wb_cpu_cyc & mapped & (d == SEL_W'(gi)) & (state_reg != RESP);
      end
   endgenerate

   assign done = mapped & (~mask_pad[d] | ack_pad[d]);

   assign o_wb_s_adr = i_wb_cpu_adr;
   assign o_wb_s_dat = i_wb_cpu_dat;
   assign o_wb_s_sel = i_wb_cpu_sel;
   assign o_wb_s_we  = i_wb_cpu_we;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ack_next       = 1'b0;
      err_next       = 1'b0;
      rdt_next       = rdt_reg;
      fault_next     = fault_reg;
      fault_adr_next = fault_adr_reg;
      case (state_reg)
         IDLE: begin
            if (i_wb_cpu_cyc) begin
               if (!mapped) begin
                  state_next     = RESP;
                  err_next       = 1'b1;
                  fault_next     = 1'b1;
                  fault_adr_next = i_wb_cpu_adr;
               end else if (done) begin
                  state_next = RESP;
                  ack_next   = 1'b1;
                  rdt_next   = rdt_arr[d];
               end else begin
                  state_next = BUSY;
                  cnt_next   = CNT_W'(1);
               end
            end
         end
         BUSY: begin
            if (!i_wb_cpu_cyc) begin
               state_next = IDLE;
            end else if (done) begin
               // A late ack beats a timeout landing in the same cycle.
               state_next = RESP;
               ack_next   = 1'b1;
               rdt_next   = rdt_arr[d];
            end else if ((TIMEOUT != 0) && (cnt_reg >= TMO_LAST)) begin
               state_next     = RESP;
               err_next       = 1'b1;
               fault_next     = 1'b1;
               fault_adr_next = i_wb_cpu_adr;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         ack_reg       <= 1'b0;
         err_reg       <= 1'b0;
         rdt_reg       <= 32'h0;
         fault_reg     <= 1'b0;
         fault_adr_reg <= 32'h0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ack_reg       <= ack_next;
         err_reg       <= err_next;
         rdt_reg       <= rdt_next;
         fault_reg     <= fault_next;
         fault_adr_reg <= fault_adr_next;
      end
   end

   assign o_wb_cpu_ack = ack_reg;
   assign o_wb_cpu_err = err_reg;
   assign o_wb_cpu_rdt = rdt_reg;
   assign o_fault      = fault_reg;
   assign o_fault_adr  = fault_adr_reg;

endmodule

// File: tb/tb_servant_wb_decoder.sv
// Bench for servant_wb_decoder: a default 4-slave instance and a 3-slave instance
// with timeout disabled, checked through a queue of expected responses.
module tb_servant_wb_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] adr = 32'h0;
   logic [31:0] dat = 32'h1111_2222;
   logic [3:0]  sel = 4'hF;
   logic        we  = 1'b0;

   logic         a_cyc = 1'b0;
   logic [31:0]  a_rdt, a_fault_adr, a_s_adr, a_s_dat;
   logic         a_ack, a_err, a_fault, a_s_we;
   logic [3:0]   a_s_sel, a_s_cyc;
   logic [127:0] a_s_rdt = '0;
   logic [3:0]   a_s_ack = '0;

   logic         b_cyc = 1'b0;
   logic [31:0]  b_rdt, b_fault_adr, b_s_adr, b_s_dat;
   logic         b_ack, b_err, b_fault, b_s_we;
   logic [3:0]   b_s_sel;
   logic [2:0]   b_s_cyc;
   logic [95:0]  b_s_rdt = '0;
   logic [2:0]   b_s_ack = '0;

   servant_wb_decoder #(.NS(4), .SEL_W(2), .ACK_MASK(8'b0000_1001), .TIMEOUT(16)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel), .i_wb_cpu_we(we),
      .i_wb_cpu_cyc(a_cyc), .o_wb_cpu_rdt(a_rdt), .o_wb_cpu_ack(a_ack), .o_wb_cpu_err(a_err),
      .o_wb_s_adr(a_s_adr), .o_wb_s_dat(a_s_dat), .o_wb_s_sel(a_s_sel), .o_wb_s_we(a_s_we),
      .o_wb_s_cyc(a_s_cyc), .i_wb_s_rdt(a_s_rdt), .i_wb_s_ack(a_s_ack),
      .o_fault(a_fault), .o_fault_adr(a_fault_adr)
   );

   servant_wb_decoder #(.NS(3), .SEL_W(2), .ACK_MASK(8'b0000_0001), .TIMEOUT(0)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_wb_cpu_adr(adr), .i_wb_cpu_dat(dat), .i_wb_cpu_sel(sel), .i_wb_cpu_we(we),
      .i_wb_cpu_cyc(b_cyc), .o_wb_cpu_rdt(b_rdt), .o_wb_cpu_ack(b_ack), .o_wb_cpu_err(b_err),
      .o_wb_s_adr(b_s_adr), .o_wb_s_dat(b_s_dat), .o_wb_s_sel(b_s_sel), .o_wb_s_we(b_s_we),
      .o_wb_s_cyc(b_s_cyc), .i_wb_s_rdt(b_s_rdt), .i_wb_s_ack(b_s_ack),
      .o_fault(b_fault), .o_fault_adr(b_fault_adr)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] rdt;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int          lat;
   logic        got_ack, got_err;
   logic [31:0] got_rdt;
   logic [63:0] cyc_log;
   logic [7:0]  cyc0;

   // Drives one master cycle; cycle n is the period whose sampling edge follows the n-th negedge.
   task automatic run_txn(input bit use_b, input logic [31:0] a, input int slave, input int ack_at,
                          input logic [31:0] data, input int abort_at, input int bound);
      logic [7:0] now;
      lat = -1; got_ack = 1'b0; got_err = 1'b0; got_rdt = 32'h0; cyc_log = '0; cyc0 = '0;
      for (int n = 0; n <= bound; n++) begin
         @(negedge clk);
         adr = a;
         if (use_b) begin
            b_cyc = (abort_at < 0) || (n < abort_at);
            b_s_ack = '0;
            if (n == ack_at) b_s_ack[slave] = 1'b1;
            b_s_rdt[slave*32 +: 32] = data;
         end else begin
            a_cyc = (abort_at < 0) || (n < abort_at);
            a_s_ack = '0;
            if (n == ack_at) a_s_ack[slave] = 1'b1;
            a_s_rdt[slave*32 +: 32] = data;
         end
         #1;
         now = use_b ? {5'b0, b_s_cyc} : {4'b0, a_s_cyc};
         if (n == 0) cyc0 = now;
         if (n < 64) cyc_log[n] = now[slave];
         if (n > 0 && (use_b ? (b_ack | b_err) : (a_ack | a_err))) begin
            lat = n;
            got_ack = use_b ? b_ack : a_ack;
            got_err = use_b ? b_err : a_err;
            got_rdt = use_b ? b_rdt : a_rdt;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a_cyc = 1'b0; b_cyc = 1'b0; a_s_ack = '0; b_s_ack = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      adr = 32'h4000_0000;
      #1;
      checks++; if (a_ack !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL reset_pulse: ack=%b err=%b expected 0 0", a_ack, a_err); end
      checks++; if (a_rdt !== 32'h0) begin failures++; $display("FAIL reset_rdt: got %h expected 0", a_rdt); end
      checks++; if (a_fault !== 1'b0 || a_fault_adr !== 32'h0) begin failures++; $display("FAIL reset_fault: fault=%b adr=%h expected 0 0", a_fault, a_fault_adr); end
      checks++; if (a_s_cyc !== 4'b0 || b_s_cyc !== 3'b0) begin failures++; $display("FAIL reset_scyc: a=%b b=%b expected 0 0", a_s_cyc, b_s_cyc); end
      checks++; if (a_s_adr !== 32'h4000_0000 || a_s_dat !== 32'h1111_2222 || a_s_sel !== 4'hF || a_s_we !== 1'b0) begin
         failures++; $display("FAIL broadcast: adr=%h dat=%h sel=%h we=%b expected 40000000 11112222 f 0", a_s_adr, a_s_dat, a_s_sel, a_s_we);
      end
   endtask

   task automatic test_auto_ack();
      exp_t e;
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'h0000_0001, lat: 1});
      run_txn(1'b0, 32'h4000_0000, 1, -1, 32'h0000_0001, -1, 8);
      e = sb.pop_front();
      $display("txn auto_ack adr=40000000 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (cyc0 !== 8'b0000_0010) begin failures++; $display("FAIL auto_scyc0: got %b expected 0010", cyc0[3:0]); end
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL auto_resp: lat=%0d ack=%b err=%b expected %0d %b %b", lat, got_ack, got_err, e.lat, e.ack, e.err); end
      checks++; if (got_rdt !== e.rdt) begin failures++; $display("FAIL auto_rdt: got %h expected %h", got_rdt, e.rdt); end
      idle(1);
   endtask

   task automatic test_slave_ack();
      exp_t e;
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'hDEAD_BEEF, lat: 4});
      run_txn(1'b0, 32'hC000_0010, 3, 3, 32'hDEAD_BEEF, -1, 10);
      e = sb.pop_front();
      $display("txn slave_ack adr=c0000010 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL sack_resp: lat=%0d ack=%b err=%b expected %0d %b %b", lat, got_ack, got_err, e.lat, e.ack, e.err); end
      checks++; if (got_rdt !== e.rdt) begin failures++; $display("FAIL sack_rdt: got %h expected %h", got_rdt, e.rdt); end
      checks++; if (cyc_log[4:0] !== 5'b01111) begin failures++; $display("FAIL sack_scyc: got %b expected 01111", cyc_log[4:0]); end
      idle(1);
   endtask

   task automatic test_timeout();
      exp_t e;
      sb.push_back('{ack: 1'b0, err: 1'b1, rdt: 32'hDEAD_BEEF, lat: 16});
      run_txn(1'b0, 32'h0000_0100, 0, -1, 32'h7777_7777, -1, 30);
      e = sb.pop_front();
      $display("txn timeout adr=00000100 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL tmo_resp: lat=%0d ack=%b err=%b expected %0d %b %b", lat, got_ack, got_err, e.lat, e.ack, e.err); end
      checks++; if (got_rdt !== e.rdt) begin failures++; $display("FAIL tmo_rdt_hold: got %h expected %h", got_rdt, e.rdt); end
      checks++; if (cyc_log[16:0] !== 17'h0FFFF) begin failures++; $display("FAIL tmo_scyc: got %h expected 0ffff", cyc_log[16:0]); end
      idle(1);
      #1;
      checks++; if (a_fault !== 1'b1 || a_fault_adr !== 32'h0000_0100) begin failures++; $display("FAIL tmo_fault: fault=%b adr=%h expected 1 00000100", a_fault, a_fault_adr); end
   endtask

   task automatic test_ack_vs_timeout();
      exp_t e;
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'h0000_1234, lat: 16});
      run_txn(1'b0, 32'h0000_0004, 0, 15, 32'h0000_1234, -1, 30);
      e = sb.pop_front();
      $display("txn ack_vs_timeout adr=00000004 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL race_resp: lat=%0d ack=%b err=%b expected %0d %b %b", lat, got_ack, got_err, e.lat, e.ack, e.err); end
      checks++; if (got_rdt !== e.rdt) begin failures++; $display("FAIL race_rdt: got %h expected %h", got_rdt, e.rdt); end
      idle(1);
   endtask

   task automatic test_abort();
      exp_t e;
      sb.push_back('{ack: 1'b0, err: 1'b0, rdt: 32'h0, lat: -1});
      run_txn(1'b0, 32'hC000_0000, 3, -1, 32'h0, 3, 24);
      e = sb.pop_front();
      $display("txn abort adr=c0000000 lat=%0d ack=%b err=%b", lat, got_ack, got_err);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL abort_pulse: lat=%0d ack=%b err=%b expected none", lat, got_ack, got_err); end
      checks++; if (a_fault_adr !== 32'h0000_0100) begin failures++; $display("FAIL abort_fault_adr: got %h expected 00000100", a_fault_adr); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'h0000_0055, lat: 1});
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'h0000_0066, lat: 1});
      run_txn(1'b0, 32'h4000_0000, 1, -1, 32'h0000_0055, -1, 8);
      e = sb.pop_front();
      $display("txn b2b_first adr=40000000 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_rdt !== e.rdt) begin failures++; $display("FAIL b2b_first: lat=%0d ack=%b rdt=%h expected %0d %b %h", lat, got_ack, got_rdt, e.lat, e.ack, e.rdt); end
      checks++; if (cyc_log[1:0] !== 2'b01) begin failures++; $display("FAIL b2b_resp_mask: got %b expected 01", cyc_log[1:0]); end
      run_txn(1'b0, 32'h8000_0000, 2, -1, 32'h0000_0066, -1, 8);
      e = sb.pop_front();
      $display("txn b2b_second adr=80000000 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (cyc0 !== 8'b0000_0100) begin failures++; $display("FAIL b2b_scyc0: got %b expected 0100", cyc0[3:0]); end
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_rdt !== e.rdt) begin failures++; $display("FAIL b2b_second: lat=%0d ack=%b rdt=%h expected %0d %b %h", lat, got_ack, got_rdt, e.lat, e.ack, e.rdt); end
      idle(1);
   endtask

   task automatic test_reset_busy();
      int pulses = 0;
      checks++; if (a_fault !== 1'b1) begin failures++; $display("FAIL rbusy_pre_fault: got %b expected 1", a_fault); end
      adr = 32'h0000_0000;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         a_cyc = 1'b1; a_s_ack = '0;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      $display("txn reset_busy ack=%b err=%b rdt=%h fault=%b fault_adr=%h", a_ack, a_err, a_rdt, a_fault, a_fault_adr);
      checks++; if (a_ack !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL rbusy_pulse: ack=%b err=%b expected 0 0", a_ack, a_err); end
      checks++; if (a_rdt !== 32'h0 || a_fault !== 1'b0 || a_fault_adr !== 32'h0) begin failures++; $display("FAIL rbusy_regs: rdt=%h fault=%b adr=%h expected 0 0 0", a_rdt, a_fault, a_fault_adr); end
      rst = 1'b0; a_cyc = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (a_ack || a_err) pulses++;
      end
      checks++; if (pulses !== 0 || a_fault !== 1'b0) begin failures++; $display("FAIL rbusy_after: pulses=%0d fault=%b expected 0 0", pulses, a_fault); end
   endtask

   task automatic test_unmapped();
      exp_t e;
      sb.push_back('{ack: 1'b0, err: 1'b1, rdt: 32'h0, lat: 1});
      run_txn(1'b1, 32'hC000_0000, 0, -1, 32'h0, -1, 8);
      e = sb.pop_front();
      $display("txn unmapped adr=c0000000 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (cyc0 !== 8'b0) begin failures++; $display("FAIL unmap_scyc: got %b expected 000", cyc0[2:0]); end
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err || got_rdt !== e.rdt) begin failures++; $display("FAIL unmap_resp: lat=%0d ack=%b err=%b rdt=%h expected %0d %b %b %h", lat, got_ack, got_err, got_rdt, e.lat, e.ack, e.err, e.rdt); end
      idle(1);
      #1;
      checks++; if (b_fault !== 1'b1 || b_fault_adr !== 32'hC000_0000) begin failures++; $display("FAIL unmap_fault: fault=%b adr=%h expected 1 c0000000", b_fault, b_fault_adr); end
   endtask

   task automatic test_no_timeout();
      exp_t e;
      sb.push_back('{ack: 1'b1, err: 1'b0, rdt: 32'hA5A5_0F0F, lat: 41});
      run_txn(1'b1, 32'h0000_0000, 0, 40, 32'hA5A5_0F0F, -1, 60);
      e = sb.pop_front();
      $display("txn no_timeout adr=00000000 lat=%0d ack=%b err=%b rdt=%h", lat, got_ack, got_err, got_rdt);
      checks++; if (lat !== e.lat || got_ack !== e.ack || got_err !== e.err) begin failures++; $display("FAIL notmo_resp: lat=%0d ack=%b err=%b expected %0d %b %b", lat, got_ack, got_err, e.lat, e.ack, e.err); end
      checks++; if (got_rdt !== e.rdt) begin failures++; $display("FAIL notmo_rdt: got %h expected %h", got_rdt, e.rdt); end
      checks++; if (cyc_log[41:0] !== {1'b0, {41{1'b1}}}) begin failures++; $display("FAIL notmo_scyc: got %h expected 1ffffffffff", cyc_log[41:0]); end
      idle(1);
   endtask

   initial begin
      test_reset();
      test_auto_ack();
      test_slave_ack();
      test_timeout();
      test_ack_vs_timeout();
      test_abort();
      test_back_to_back();
      test_reset_busy();
      test_unmapped();
      test_no_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
